// File: rtl/oven_pkg.sv
// oven_pkg: state encoding, BCD digit type and BCD time arithmetic shared by the oven controller.
package oven_pkg;
   typedef enum logic [2:0] {S_OFF, S_SET_TEMP, S_SET_TIME, S_PREHEAT, S_BAKE, S_DONE} state_t;
   typedef logic [3:0] bcd_t;
   function automatic int tick_w(input int div);
      return div > 1 ? $clog2(div) : 1;
   endfunction
   function automatic logic [15:0] mmss_inc(input logic [15:0] t);
      if (t[3:0] != 4'd9) return {t[15:4], t[3:0] + 4'd1};
      if (t[7:4] != 4'd5) return {t[15:8], t[7:4] + 4'd1, 4'd0};
      if (t[11:8] != 4'd9) return {t[15:12], t[11:8] + 4'd1, 8'd0};
      return {t[15:12] == 4'd5 ? 4'd0 : t[15:12] + 4'd1, 12'd0};
   endfunction
   // Saturates at 00:00 so a stray decrement can never wrap the cook time.
   function automatic logic [15:0] mmss_dec(input logic [15:0] t);
      if (t[3:0] != 4'd0) return {t[15:4], t[3:0] - 4'd1};
      if (t[7:4] != 4'd0) return {t[15:8], t[7:4] - 4'd1, 4'd9};
      if (t[11:8] != 4'd0) return {t[15:12], t[11:8] - 4'd1, 8'h59};
      if (t[15:12] != 4'd0) return {t[15:12] - 4'd1, 12'h959};
      return t;
   endfunction
   function automatic logic [7:0] min_inc(input logic [7:0] m, input logic [7:0] max);
      if (m >= max) return m;
      return m[3:0] == 4'd9 ? {m[7:4] + 4'd1, 4'd0} : {m[7:4], m[3:0] + 4'd1};
   endfunction
   function automatic logic [7:0] min_dec(input logic [7:0] m);
      if (m == 8'h00) return m;
      return m[3:0] == 4'd0 ? {m[7:4] - 4'd1, 4'd9} : {m[7:4], m[3:0] - 4'd1};
   endfunction
endpackage

// File: rtl/oven_bin2bcd.sv
// oven_bin2bcd: combinational double-dabble conversion of a binary value below 1000 to three BCD digits.
module oven_bin2bcd import oven_pkg::*; #(
   parameter int W = 10
) (
   input  logic [W-1:0] bin,
   output bcd_t         hun,
   output bcd_t         ten,
   output bcd_t         one
);
   logic [W+11:0] sr;
   always_comb begin
      sr = {12'd0, bin};
      for (int i = 0; i < W; i++) begin
         for (int d = 0; d < 3; d++)
            sr[W+4*d +: 4] = sr[W+4*d +: 4] > 4'd4 ? sr[W+4*d +: 4] + 4'd3 : sr[W+4*d +: 4];
         sr = sr << 1;
      end
   end
   assign hun = sr[W+8 +: 4];
   assign ten = sr[W+4 +: 4];
   assign one = sr[W +: 4];
endmodule

// File: rtl/oven_ctrl.sv
// oven_ctrl: front-panel oven controller with MM:SS wall clock, setpoint/cook-time entry,
// preheat/bake/done sequencing, a first-order temperature model and a registered 4-digit display.
module oven_ctrl import oven_pkg::*; #(
   parameter int TICK_DIV     = 50_000_000,
   parameter int TEMP_W       = 10,
   parameter int TEMP_MIN     = 150,
   parameter int TEMP_MAX     = 500,
   parameter int TEMP_STEP    = 25,
   parameter int TEMP_DEFAULT = 350,
   parameter int AMBIENT      = 70,
   parameter int RAMP_UP      = 5,
   parameter int RAMP_DN      = 2,
   parameter int MAX_MIN      = 99
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              power,
   input  logic              up,
   input  logic              dn,
   input  logic              start,
   input  logic              time_set,
   output logic [3:0]        bcd3,
   output logic [3:0]        bcd2,
   output logic [3:0]        bcd1,
   output logic [3:0]        bcd0,
   output logic [3:0]        blank,
   output logic              heater,
   output logic              done,
   output logic [2:0]        state,
   output logic [TEMP_W-1:0] cur_temp
);
   localparam int TW = tick_w(TICK_DIV);
   localparam logic [TEMP_W:0] T_MIN  = (TEMP_W+1)'(TEMP_MIN);
   localparam logic [TEMP_W:0] T_MAX  = (TEMP_W+1)'(TEMP_MAX);
   localparam logic [TEMP_W:0] T_STEP = (TEMP_W+1)'(TEMP_STEP);
   localparam logic [TEMP_W:0] T_DEF  = (TEMP_W+1)'(TEMP_DEFAULT);
   localparam logic [TEMP_W:0] T_AMB  = (TEMP_W+1)'(AMBIENT);
   localparam logic [TEMP_W:0] R_UP   = (TEMP_W+1)'(RAMP_UP);
   localparam logic [TEMP_W:0] R_DN   = (TEMP_W+1)'(RAMP_DN);
   localparam logic [7:0] MAX_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

   state_t st, nst;
   logic [TW-1:0] cnt;
   logic [3:0] btn_q, btn_e, blank_d;
   logic [15:0] wall, cook, dig, dig_d;
   logic [7:0] prog, min_nx;
   logic [TEMP_W-1:0] sp, sp_nx, temp_nx, tsrc;
   logic [TEMP_W:0] sp_up, t_up;
   bcd_t hun, ten, one;
   logic tick, inc, dec, cook_z, temp_mode;

   assign tick = cnt == TW'(TICK_DIV - 1);
   assign btn_e = {up, dn, start, time_set} & ~btn_q;
   // Simultaneous up and down edges cancel each other.
   assign inc = btn_e[3] & ~btn_e[2];
   assign dec = btn_e[2] & ~btn_e[3];
   assign cook_z = cook == 16'h0000;
   assign sp_up = {1'b0, sp} + T_STEP;
   assign sp_nx = inc ? (sp_up > T_MAX ? T_MAX[TEMP_W-1:0] : sp_up[TEMP_W-1:0])
                : dec ? ({1'b0, sp} < T_MIN + T_STEP ? T_MIN[TEMP_W-1:0] : sp - T_STEP[TEMP_W-1:0]) : sp;
   assign min_nx = inc ? min_inc(cook[15:8], MAX_BCD) : dec ? min_dec(cook[15:8]) : cook[15:8];
   assign heater = (st == S_PREHEAT || st == S_BAKE) && cur_temp < sp;
   assign t_up = {1'b0, cur_temp} + R_UP;
   assign temp_nx = heater ? (t_up > T_MAX ? T_MAX[TEMP_W-1:0] : t_up[TEMP_W-1:0])
                  : {1'b0, cur_temp} < T_AMB + R_DN ? T_AMB[TEMP_W-1:0] : cur_temp - R_DN[TEMP_W-1:0];

   always_ff @(posedge clk)
      st <= !rst_n ? S_OFF : nst;

   always_comb begin
      nst = st;
      if (!power)
         nst = S_OFF;
      else
         case (st)
            S_OFF:      nst = S_SET_TEMP;
            S_SET_TEMP: nst = btn_e[1] && !cook_z ? S_PREHEAT : btn_e[0] ? S_SET_TIME : st;
            S_SET_TIME: nst = btn_e[1] && !cook_z ? S_PREHEAT : btn_e[0] ? S_SET_TEMP : st;
            S_PREHEAT:  nst = btn_e[1] ? S_SET_TEMP : cur_temp >= sp ? S_BAKE : st;
            S_BAKE:     nst = btn_e[1] ? S_SET_TEMP : cook_z ? S_DONE : st;
            S_DONE:     nst = |btn_e ? S_SET_TEMP : st;
            default:    nst = S_OFF;
         endcase
   end

   // One converter serves both temperature views: setpoint while editing, model while preheating.
   assign tsrc = st == S_PREHEAT ? cur_temp : sp;
   oven_bin2bcd #(.W(TEMP_W)) u_bcd (.bin(tsrc), .hun(hun), .ten(ten), .one(one));
   assign temp_mode = st == S_SET_TEMP || st == S_PREHEAT;

   always_comb begin
      dig_d = temp_mode ? {4'd0, hun, ten, one} : st == S_OFF ? wall
            : (st == S_SET_TIME || st == S_BAKE) ? cook : 16'h0000;
      blank_d = temp_mode ? {1'b1, hun == 4'd0, hun == 4'd0 && ten == 4'd0, 1'b0} : 4'b0000;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
         btn_q <= '0;
         wall <= '0;
         cook <= '0;
         prog <= '0;
         sp <= T_DEF[TEMP_W-1:0];
         cur_temp <= T_AMB[TEMP_W-1:0];
         dig <= '0;
         blank <= '0;
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         btn_q <= {up, dn, start, time_set};
         wall <= tick ? mmss_inc(wall) : wall;
         cur_temp <= tick ? temp_nx : cur_temp;
         sp <= st == S_SET_TEMP ? sp_nx : sp;
         prog <= st == S_SET_TIME ? min_nx : prog;
         cook <= st == S_SET_TIME ? {min_nx, 8'h00}
               : st == S_BAKE && tick ? mmss_dec(cook)
               : st == S_DONE && |btn_e ? {prog, 8'h00} : cook;
         dig <= dig_d;
         blank <= blank_d;
      end
   end

   assign {bcd3, bcd2, bcd1, bcd0} = dig;
   assign done = st == S_DONE;
   assign state = st;
endmodule

// File: tb/tb_oven_ctrl.sv
// tb_oven_ctrl: directed self-checking bench for oven_ctrl with a 4-cycle tick.
module tb_oven_ctrl;
   logic clk = 1'b0, rst_n = 1'b0, power = 1'b0;
   logic up = 1'b0, dn = 1'b0, start = 1'b0, time_set = 1'b0;
   logic [3:0] bcd3, bcd2, bcd1, bcd0, blank;
   logic heater, done;
   logic [2:0] state;
   logic [9:0] cur_temp;
   logic [15:0] disp;
   int checks = 0, errors = 0, pc = 0;
   int bake_t [5] = '{148, 153, 151, 149, 154};

   assign disp = {bcd3, bcd2, bcd1, bcd0};

   oven_ctrl #(.TICK_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .power(power), .up(up), .dn(dn), .start(start),
      .time_set(time_set), .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
      .blank(blank), .heater(heater), .done(done), .state(state), .cur_temp(cur_temp)
   );

   always #5 clk = ~clk;
   // Posedges since reset release; a tick lands on every posedge where pc % 4 == 0.
   always @(posedge clk) pc <= rst_n ? pc + 1 : 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_tick();
      do @(negedge clk); while (pc % 4 != 0);
   endtask

   task automatic press(input logic [3:0] b);
      {up, dn, start, time_set} = b;
      @(negedge clk);
      {up, dn, start, time_set} = 4'b0000;
      @(negedge clk);
   endtask

   function automatic logic [15:0] mmss(input int s);
      return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
   endfunction

   initial begin
      repeat (3) @(negedge clk);
      check("rst_state", state, 0);
      check("rst_disp", disp, 0);
      check("rst_blank", blank, 0);
      check("rst_heater", heater, 0);
      check("rst_done", done, 0);
      check("rst_temp", cur_temp, 70);
      rst_n = 1'b1;
      @(negedge clk);
      check("clock_start", disp, 0);
      for (int k = 1; k <= 3600; k++) begin
         wait_tick();
         @(negedge clk);
         check("clock", disp, mmss(k % 3600));
      end
      check("clock_state", state, 0);
      check("clock_heater", heater, 0);
      power = 1'b1;
      @(negedge clk);
      check("pwr_state", state, 1);
      @(negedge clk);
      check("sp_default", disp, 16'h0350);
      check("sp_blank", blank, 4'b1000);
      repeat (10) press(4'b1000);
      check("sp_max", disp, 16'h0500);
      repeat (20) press(4'b0100);
      check("sp_min", disp, 16'h0150);
      press(4'b1100);
      @(negedge clk);
      check("sp_updn", disp, 16'h0150);
      press(4'b0010);
      check("start_nocook", state, 1);
      press(4'b0001);
      check("to_time", state, 2);
      check("time_disp", disp, 0);
      check("time_blank", blank, 0);
      press(4'b0100);
      check("min_floor", disp, 0);
      press(4'b1000);
      press(4'b1000);
      check("cook_0200", disp, 16'h0200);
      press(4'b0100);
      check("cook_0100", disp, 16'h0100);
      wait_tick();
      press(4'b0010);
      check("preheat", state, 3);
      check("ph_heater", heater, 1);
      check("ph_disp", disp, 16'h0070);
      check("ph_blank", blank, 4'b1100);
      for (int t = 1; t <= 16; t++) begin
         wait_tick();
         check("ph_temp", cur_temp, 70 + 5 * t);
      end
      check("ph_end_state", state, 3);
      check("ph_end_heater", heater, 0);
      @(negedge clk);
      check("bake", state, 4);
      @(negedge clk);
      check("bake_disp", disp, 16'h0100);
      for (int k = 1; k <= 60; k++) begin
         wait_tick();
         if (k <= 5) check("bake_temp", cur_temp, bake_t[k-1]);
         @(negedge clk);
         check("bake_count", disp, mmss(60 - k));
      end
      check("done_state", state, 5);
      check("done_flag", done, 1);
      check("done_heater", heater, 0);
      @(negedge clk);
      check("done_disp", disp, 0);
      press(4'b1000);
      check("done_exit", state, 1);
      check("done_clear", done, 0);
      press(4'b0001);
      check("cook_reload", disp, 16'h0100);
      repeat (60) wait_tick();
      check("cool_floor", cur_temp, 70);
      wait_tick();
      press(4'b0010);
      check("restart", state, 3);
      repeat (16) wait_tick();
      @(negedge clk);
      check("bake2", state, 4);
      wait_tick();
      check("bake2_temp", cur_temp, 148);
      power = 1'b0;
      @(negedge clk);
      check("pwr_off", state, 0);
      @(negedge clk);
      check("off_clock", disp, mmss(((pc - 1) / 4) % 3600));
      for (int i = 1; i <= 44; i++) begin
         wait_tick();
         check("decay", cur_temp, 148 - 2 * i > 70 ? 148 - 2 * i : 70);
      end
      check("off_heater", heater, 0);
      power = 1'b1;
      @(negedge clk);
      check("pwr_on", state, 1);
      @(negedge clk);
      check("sp_kept", disp, 16'h0150);
      wait_tick();
      press(4'b0010);
      check("restart2", state, 3);
      repeat (16) wait_tick();
      @(negedge clk);
      check("bake3", state, 4);
      @(negedge clk);
      check("cook_kept", disp, 16'h0059);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_state", state, 0);
      check("mid_rst_heater", heater, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_temp", cur_temp, 70);
      check("mid_rst_disp", disp, 0);
      check("mid_rst_blank", blank, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_sp", disp, 16'h0350);
      press(4'b0001);
      check("rst_cook", disp, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
